// File: rtl/axil_register_responder.sv
// AXI-lite slave that terminates AW/W/B and AR/R into a flat bank of
// N_REGISTERS control registers, exposing their contents and write strobes.
//
// Ports:
//   clock, reset            system clock, asynchronous active-low reset
//   axi_aw*                 write address channel (one-entry holding register)
//   axi_w*                  write data channel (one-entry holding register)
//   axi_b*                  write response channel
//   axi_ar*, axi_r*         read address / read data channels
//   registers_out           register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   write_pulse             one-cycle strobe per committed register write
module axil_register_responder #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            N_REGISTERS  = 8,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDRESS = '0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             axi_awaddr,
  input  logic                              axi_awvalid,
  output logic                              axi_awready,
  input  logic [DATA_WIDTH-1:0]             axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]           axi_wstrb,
  input  logic                              axi_wvalid,
  output logic                              axi_wready,
  output logic [1:0]                        axi_bresp,
  output logic                              axi_bvalid,
  input  logic                              axi_bready,
  input  logic [ADDR_WIDTH-1:0]             axi_araddr,
  input  logic                              axi_arvalid,
  output logic                              axi_arready,
  output logic [DATA_WIDTH-1:0]             axi_rdata,
  output logic [1:0]                        axi_rresp,
  output logic                              axi_rvalid,
  input  logic                              axi_rready,
  output logic [N_REGISTERS*DATA_WIDTH-1:0] registers_out,
  output logic [N_REGISTERS-1:0]            write_pulse
);

  localparam int unsigned STRB  = DATA_WIDTH / 8;
  localparam int unsigned LSB_W = $clog2(STRB);
  localparam int unsigned IDX_W = (N_REGISTERS > 1) ? $clog2(N_REGISTERS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address decode: below base, misaligned, or past the last register.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDRESS;
    return (addr < BASE_ADDRESS) ||
           (offset[LSB_W-1:0] != '0) ||
           ((offset >> LSB_W) >= ADDR_WIDTH'(N_REGISTERS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDRESS;
    return IDX_W'(offset >> LSB_W);
  endfunction

  // AW holding register stores the decoded address so the commit path is short.
  logic                   aw_full_q, aw_full_d;
  logic                   aw_err_q,  aw_err_d;
  logic [IDX_W-1:0]       aw_idx_q,  aw_idx_d;
  logic                   w_full_q,  w_full_d;
  logic [DATA_WIDTH-1:0]  wdata_q,   wdata_d;
  logic [STRB-1:0]        wstrb_q,   wstrb_d;
  logic                   bvalid_q,  bvalid_d;
  logic [1:0]             bresp_q,   bresp_d;
  logic                   rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q,   rdata_d;
  logic [1:0]             rresp_q,   rresp_d;
  logic [N_REGISTERS-1:0] pulse_q,   pulse_d;
  logic [DATA_WIDTH-1:0]  regs_q [N_REGISTERS];
  logic [DATA_WIDTH-1:0]  regs_d [N_REGISTERS];

  logic             aw_hs_c, w_hs_c, ar_hs_c, commit_c;
  logic             ar_err_c;
  logic [IDX_W-1:0] ar_idx_c;

  // Next-state logic for both channels and the register bank.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_err_d  = aw_err_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    aw_hs_c  = axi_awvalid & ~aw_full_q;
    w_hs_c   = axi_wvalid  & ~w_full_q;
    ar_hs_c  = axi_arvalid & ~rvalid_q;
    commit_c = aw_full_q & w_full_q & (~bvalid_q | axi_bready);
    ar_err_c = addr_err(axi_araddr);
    ar_idx_c = addr_idx(axi_araddr);

    // B handshake frees the response slot; a coinciding commit refills it.
    if (bvalid_q && axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (commit_c) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_err_q ? RESP_SLVERR : RESP_OKAY;
      if (!aw_err_q) begin
        pulse_d[aw_idx_q] = 1'b1;
        for (int b = 0; b < STRB; b++) begin
          if (wstrb_q[b]) begin
            regs_d[aw_idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
          end
        end
      end
    end

    // Holding registers are only loaded when empty, so never race the commit.
    if (aw_hs_c) begin
      aw_full_d = 1'b1;
      aw_err_d  = addr_err(axi_awaddr);
      aw_idx_d  = addr_idx(axi_awaddr);
    end
    if (w_hs_c) begin
      w_full_d = 1'b1;
      wdata_d  = axi_wdata;
      wstrb_d  = axi_wstrb;
    end

    // Read samples regs_q, so a same-edge commit is not visible yet.
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_err_c ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = ar_err_c ? '0 : regs_q[ar_idx_c];
    end else if (rvalid_q && axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_full_q <= 1'b0;
      aw_err_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      for (int i = 0; i < N_REGISTERS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_full_q <= aw_full_d;
      aw_err_q  <= aw_err_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < N_REGISTERS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign axi_awready = ~aw_full_q;
  assign axi_wready  = ~w_full_q;
  assign axi_arready = ~rvalid_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign write_pulse = pulse_q;

  // Flatten the bank onto the datapath bus.
  for (genvar gi = 0; gi < N_REGISTERS; gi++) begin : g_flat
    assign registers_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

endmodule

// File: tb/tb_axil_register_responder.sv
// Randomised and directed bench for axil_register_responder (default params).
module tb_axil_register_responder;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic [NR*DW-1:0] registers_out;
  logic [NR-1:0]   write_pulse;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model [NR];

  axil_register_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REGISTERS(NR), .BASE_ADDRESS('0)
  ) dut (
    .clock(clk), .reset(rst_n),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .registers_out(registers_out), .write_pulse(write_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: word-addressed array starting at byte address 0.
  function automatic bit model_err(input logic [AW-1:0] a);
    return ((a % 32'd4) != 0) || ((a / 32'd4) >= NR);
  endfunction

  function automatic logic [1:0] model_resp(input logic [AW-1:0] a);
    return model_err(a) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [NR-1:0] model_pulse(input logic [AW-1:0] a);
    logic [NR-1:0] p;
    p = '0;
    if (!model_err(a)) p[a / 32'd4] = 1'b1;
    return p;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return model_err(a) ? '0 : model[a / 32'd4];
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] s);
    if (!model_err(a)) begin
      for (int b = 0; b < DW/8; b++) begin
        if (s[b]) model[a / 32'd4][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents AW and W together, waits for B with bready=1, completes the handshake.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, output logic [1:0] resp,
                          output logic [NR-1:0] pulse, output int acc, output int lat);
    bit aw_p, w_p, aw_h, w_h;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; acc = 0;
    while ((aw_p || w_p) && acc < 50) begin
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      step(); acc++;
      if (aw_h) begin awvalid = 1'b0; aw_p = 1'b0; end
      if (w_h)  begin wvalid  = 1'b0; w_p  = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin step(); lat++; end
    if (acc >= 50 || lat >= 50) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr=%h observed acc=%0d lat=%0d, required < 50", a, acc, lat);
    end
    resp = bresp; pulse = write_pulse;
    step();
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                         output logic [1:0] resp, output bit ok);
    bit h;
    int cyc;
    araddr = a; arvalid = 1'b1; cyc = 0; h = 1'b0;
    while (!h && cyc < 50) begin
      h = arvalid && arready;
      step(); cyc++;
    end
    arvalid = 1'b0;
    ok = h && rvalid;
    d = rdata; resp = rresp;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #23;
    vectors++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      miscompares++;
      $display("FAIL reset_handshake observed %b required 11100",
               {awready, wready, arready, bvalid, rvalid});
    end
    vectors++;
    if ({bresp, rresp, rdata, write_pulse} !== '0 || registers_out !== '0) begin
      miscompares++;
      $display("FAIL reset_values observed bresp=%b rresp=%b rdata=%h pulse=%h regs=%h required all zero",
               bresp, rresp, rdata, write_pulse, registers_out);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_same_cycle();
    logic [1:0] r; logic [NR-1:0] p; int acc, lat;
    do_write(32'h4, 32'hCAFECABE, 4'hF, r, p, acc, lat);
    model_write(32'h4, 32'hCAFECABE, 4'hF);
    vectors++;
    if (acc !== 1 || lat !== 1) begin
      miscompares++;
      $display("FAIL same_cycle_latency observed acc=%0d lat=%0d required 1 1", acc, lat);
    end
    vectors++;
    if (r !== 2'b00 || p !== 8'h02) begin
      miscompares++;
      $display("FAIL same_cycle_resp observed resp=%b pulse=%h required 00 02", r, p);
    end
    vectors++;
    if (registers_out[63:32] !== 32'hCAFECABE || write_pulse !== '0) begin
      miscompares++;
      $display("FAIL same_cycle_reg observed reg1=%h pulse=%h required cafecabe 00",
               registers_out[63:32], write_pulse);
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'hDEADCAFE; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step(); step();
    vectors++;
    if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
      miscompares++;
      $display("FAIL w_first_hold observed wready=%b bvalid=%b awready=%b required 0 0 1",
               wready, bvalid, awready);
    end
    awaddr = 32'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    vectors++;
    if (bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL w_first_early observed bvalid=%b required 0", bvalid);
    end
    step();
    model_write(32'h8, 32'hDEADCAFE, 4'hF);
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || write_pulse !== 8'h04 ||
        registers_out !== model_flat()) begin
      miscompares++;
      $display("FAIL w_first_commit observed bvalid=%b bresp=%b pulse=%h reg2=%h required 1 00 04 deadcafe",
               bvalid, bresp, write_pulse, registers_out[95:64]);
    end
    step();
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [NR-1:0] p; int acc, lat;
    do_write(32'h4, 32'h11112222, 4'h3, r, p, acc, lat);
    model_write(32'h4, 32'h11112222, 4'h3);
    vectors++;
    if (r !== 2'b00 || registers_out[63:32] !== 32'hCAFE2222 || registers_out !== model_flat()) begin
      miscompares++;
      $display("FAIL strobe observed resp=%b reg1=%h required 00 cafe2222", r, registers_out[63:32]);
    end
  endtask

  task automatic test_b_backpressure();
    logic [DW-1:0] d;
    bit stable;
    d = $urandom;
    bready = 1'b0;
    awaddr = 32'hC; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    model_write(32'hC, d, 4'hF);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bvalid !== 1'b1 || bresp !== 2'b00) stable = 1'b0;
      step();
    end
    vectors++;
    if (!stable || registers_out !== model_flat()) begin
      miscompares++;
      $display("FAIL b_hold observed bvalid=%b bresp=%b reg3=%h required 1 00 %h",
               bvalid, bresp, registers_out[127:96], d);
    end
    awaddr = 32'h20; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step(); step();
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
      miscompares++;
      $display("FAIL b_second_stall observed bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
               bvalid, bresp, awready, wready);
    end
    bready = 1'b1;
    step();
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b10 || write_pulse !== '0 ||
        registers_out !== model_flat()) begin
      miscompares++;
      $display("FAIL b_second_commit observed bvalid=%b bresp=%b pulse=%h required 1 10 00",
               bvalid, bresp, write_pulse);
    end
    step();
    vectors++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      miscompares++;
      $display("FAIL b_drain observed bvalid=%b awready=%b wready=%b required 0 1 1",
               bvalid, awready, wready);
    end
  endtask

  task automatic test_read_backpressure();
    bit stable;
    rready = 1'b0;
    araddr = 32'h4; arvalid = 1'b1;
    step();
    araddr = 32'h8;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rvalid !== 1'b1 || rdata !== 32'hCAFE2222 || rresp !== 2'b00 || arready !== 1'b0)
        stable = 1'b0;
      step();
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL r_hold observed rvalid=%b rdata=%h rresp=%b arready=%b required 1 cafe2222 00 0",
               rvalid, rdata, rresp, arready);
    end
    rready = 1'b1;
    step();
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL r_release observed rvalid=%b arready=%b required 0 1", rvalid, arready);
    end
    step();
    arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b1 || rdata !== model_read(32'h8) || rresp !== 2'b00) begin
      miscompares++;
      $display("FAIL r_next observed rvalid=%b rdata=%h required 1 %h", rvalid, rdata, model_read(32'h8));
    end
    step();
  endtask

  task automatic test_collision();
    logic [1:0] r; logic [NR-1:0] p; int acc, lat;
    logic [DW-1:0] old_v, new_v;
    old_v = $urandom; new_v = ~old_v;
    do_write(32'h14, old_v, 4'hF, r, p, acc, lat);
    model_write(32'h14, old_v, 4'hF);
    awaddr = 32'h14; wdata = new_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h14; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b1 || rdata !== model_read(32'h14) || bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL collision observed rvalid=%b rdata=%h bvalid=%b required 1 %h 1",
               rvalid, rdata, bvalid, old_v);
    end
    model_write(32'h14, new_v, 4'hF);
    step();
    vectors++;
    if (registers_out !== model_flat()) begin
      miscompares++;
      $display("FAIL collision_reg observed reg5=%h required %h", registers_out[191:160], new_v);
    end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [NR-1:0] p; int acc, lat;
    logic [DW-1:0] d; bit ok;
    logic [AW-1:0] bad [2];
    bad[0] = 32'h20; bad[1] = 32'h6;
    for (int i = 0; i < 2; i++) begin
      do_write(bad[i], 32'hFFFFFFFF, 4'hF, r, p, acc, lat);
      vectors++;
      if (r !== 2'b10 || p !== '0 || registers_out !== model_flat()) begin
        miscompares++;
        $display("FAIL err_write addr=%h observed resp=%b pulse=%h required 10 00", bad[i], r, p);
      end
      do_read(bad[i], d, r, ok);
      vectors++;
      if (!ok || r !== 2'b10 || d !== '0) begin
        miscompares++;
        $display("FAIL err_read addr=%h observed ok=%b resp=%b data=%h required 1 10 0", bad[i], ok, r, d);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] r; logic [NR-1:0] p; int acc, lat;
    logic [DW-1:0] d; logic [DW/8-1:0] s; logic [AW-1:0] a; bit ok;
    logic [1:0] er; logic [NR-1:0] ep; logic [DW-1:0] ed;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 40)) : AW'($urandom_range(0, 8) * 4);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = DW'($urandom_range(0, 15));
        er = model_resp(a); ep = model_pulse(a);
        do_write(a, d, s, r, p, acc, lat);
        model_write(a, d, s);
        vectors++;
        if (r !== er || p !== ep || lat !== 1 || registers_out !== model_flat()) begin
          miscompares++;
          $display("FAIL rand_write addr=%h observed resp=%b pulse=%h lat=%0d required %b %h 1",
                   a, r, p, lat, er, ep);
        end
      end else begin
        er = model_resp(a); ed = model_read(a);
        do_read(a, d, r, ok);
        vectors++;
        if (!ok || r !== er || d !== ed) begin
          miscompares++;
          $display("FAIL rand_read addr=%h observed ok=%b resp=%b data=%h required 1 %b %h",
                   a, ok, r, d, er, ed);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d; logic [1:0] r; bit ok, all_zero;
    bready = 1'b0;
    awaddr = 32'h0; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    vectors++;
    if (bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre observed bvalid=%b required 1", bvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    vectors++;
    if (bvalid !== 1'b0 || registers_out !== '0 || write_pulse !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_async observed bvalid=%b regs=%h pulse=%h required 0 0 0",
               bvalid, registers_out, write_pulse);
    end
    step();
    rst_n = 1'b1; bready = 1'b1;
    step();
    all_zero = 1'b1;
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(i * 4), d, r, ok);
      if (!ok || d !== '0 || r !== 2'b00) all_zero = 1'b0;
    end
    vectors++;
    if (!all_zero || bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_readback observed all_zero=%b bvalid=%b required 1 0", all_zero, bvalid);
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_strobe();
    test_b_backpressure();
    test_read_backpressure();
    test_collision();
    test_errors();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
